// File: rtl/parity_frame_rx_pkg.sv
// Shared constants for the parity frame receive path: FSM encodings and parity modes.
// The parity mode constants are also used by the transmit-side generator.
package parity_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // A nonzero result means the received parity bit disagrees with the data.
  function automatic logic parity_err(input logic running, input logic pbit, input logic mode);
    return running ^ pbit ^ mode;
  endfunction

endpackage

// File: rtl/parity_frame_rx_timeout.sv
// Idle timeout counter for frames in progress. It is held clear while disabled or kicked,
// and it pulses expired on the TIMEOUT-th consecutive idle cycle.
module idle_timeout_counter
  import parity_frame_rx_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == LIMIT) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || !enable || kick) begin
      cnt <= '0;
    end else begin
      cnt <= sat_inc(cnt);
    end
  end

  // Combinational so the parent can register the abort on the same edge the count reaches TIMEOUT.
  assign expired = enable & ~kick & (cnt == LAST);

endmodule

// File: rtl/parity_frame_rx.sv
// Serial parity-checked frame receiver: start bit, DATA_W bits LSB first, then one parity bit.
// The word is presented on a valid/ready handshake, and stalled partial frames are aborted.
module parity_frame_rx
  import parity_frame_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_abort,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic PAR_MODE = (ODD_PARITY != 0) ? ODD : EVEN;

  state_t            state, state_next;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
  logic              run_par, run_par_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] data_next;
  logic              err_next, valid_next, abort_next, overrun_next;
  logic              timeout_en, expired;

  assign timeout_en = (state == DATA) || (state == PARITY);

  idle_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (timeout_en),
    .kick    (bit_valid),
    .expired (expired)
  );

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    run_par_next = run_par;
    shift_next   = shift_reg;
    data_next    = out_data;
    err_next     = out_par_err;
    valid_next   = out_valid;
    abort_next   = 1'b0;
    overrun_next = 1'b0;

    case (state)
      IDLE: begin
        if (bit_valid && bit_in) begin
          state_next   = DATA;
          bit_cnt_next = '0;
          run_par_next = 1'b0;
          shift_next   = '0;
        end
      end
      DATA: begin
        if (bit_valid) begin
          shift_next[bit_cnt[IDX_W-1:0]] = bit_in;
          run_par_next = run_par ^ bit_in;
          bit_cnt_next = bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) state_next = PARITY;
        end else if (expired) begin
          abort_next = 1'b1;
          shift_next = '0;
          state_next = IDLE;
        end
      end
      PARITY: begin
        if (bit_valid) begin
          data_next  = shift_reg;
          err_next   = parity_err(run_par, bit_in, PAR_MODE);
          valid_next = 1'b1;
          state_next = HOLD;
        end else if (expired) begin
          abort_next = 1'b1;
          shift_next = '0;
          state_next = IDLE;
        end
      end
      HOLD: begin
        // Anything arriving while a word is held is lost, even on the handshake cycle.
        overrun_next = bit_valid;
        if (out_ready) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      frame_abort <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      out_valid   <= valid_next;
      frame_abort <= abort_next;
      overrun     <= overrun_next;
      busy        <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      run_par     <= 1'b0;
      shift_reg   <= '0;
      out_data    <= '0;
      out_par_err <= 1'b0;
    end else begin
      bit_cnt     <= bit_cnt_next;
      run_par     <= run_par_next;
      shift_reg   <= shift_next;
      out_data    <= data_next;
      out_par_err <= err_next;
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Scoreboard bench for parity_frame_rx: an even-parity and an odd-parity instance with
// directed frames, backpressure, overrun, timeout and mid-frame reset.
module tb_parity_frame_rx;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic out_ready = 1'b0;
  logic sel_odd = 1'b0;
  logic bv0, bv1;
  logic [7:0] data0, data1;
  logic err0, err1, vld0, vld1, abort0, abort1, ovr0, ovr1, busy0, busy1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int n_tests = 0;
  int n_fail = 0;
  int abort_cnt0 = 0, ovr_cnt0 = 0, abort_cnt1 = 0, ovr_cnt1 = 0;
  int base;

  assign bv0 = bit_valid & ~sel_odd;
  assign bv1 = bit_valid & sel_odd;

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(0), .TIMEOUT(16)) u_even (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bv0),
    .out_data(data0), .out_par_err(err0), .out_valid(vld0), .out_ready(out_ready),
    .frame_abort(abort0), .overrun(ovr0), .busy(busy0)
  );

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1), .TIMEOUT(16)) u_odd (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bv1),
    .out_data(data1), .out_par_err(err1), .out_valid(vld1), .out_ready(out_ready),
    .frame_abort(abort1), .overrun(ovr1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and tallies pulse outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (abort0 === 1'b1) abort_cnt0++;
      if (ovr0 === 1'b1) ovr_cnt0++;
      if (abort1 === 1'b1) abort_cnt1++;
      if (ovr1 === 1'b1) ovr_cnt1++;
      if (vld0 === 1'b1 && out_ready) begin
        if (q0.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL word_even: unexpected word %0h, none expected", data0);
        end else begin
          e0 = q0.pop_front();
          check("word_even_data", 32'(data0), 32'(e0.data));
          check("word_even_err", 32'(err0), 32'(e0.err));
        end
      end
      if (vld1 === 1'b1 && out_ready) begin
        if (q1.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL word_odd: unexpected word %0h, none expected", data1);
        end else begin
          e1 = q1.pop_front();
          check("word_odd_data", 32'(data1), 32'(e1.data));
          check("word_odd_err", 32'(err1), 32'(e1.err));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bit_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    bit_in = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    drive_bit(1'b1);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    check("rst_valid", 32'(vld0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_data", 32'(data0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_abort", 32'(abort0), 32'd0);
    check("rst_overrun", 32'(ovr0), 32'd0);
    rst_n = 1'b1;
    tick();

    // Clean even-parity frame 0xA5
    out_ready = 1'b1;
    q0.push_back('{8'hA5, 1'b0});
    send_frame(8'hA5, 1'b0);
    check("t1_valid_latency", 32'(vld0), 32'd1);
    check("t1_busy_hold", 32'(busy0), 32'd1);
    tick();
    check("t1_valid_after", 32'(vld0), 32'd0);
    check("t1_idle_after", 32'(busy0), 32'd0);

    // Parity error
    q0.push_back('{8'hA5, 1'b1});
    send_frame(8'hA5, 1'b1);
    check("t2_err_flag", 32'(err0), 32'd1);
    tick();

    // Backpressure with an overrun on hold cycle 2
    out_ready = 1'b0;
    base = ovr_cnt0;
    q0.push_back('{8'h3C, 1'b0});
    send_frame(8'h3C, 1'b0);
    for (int h = 1; h <= 5; h++) begin
      bit_valid = (h == 2);
      bit_in = 1'b1;
      check("t3_hold_valid", 32'(vld0), 32'd1);
      check("t3_hold_data", 32'(data0), 32'h3C);
      tick();
    end
    bit_valid = 1'b0;
    bit_in = 1'b0;
    check("t3_overrun_pulses", 32'(ovr_cnt0 - base), 32'd1);
    check("t3_word_pending", 32'(q0.size()), 32'd1);
    out_ready = 1'b1;
    tick();
    check("t3_word_taken", 32'(q0.size()), 32'd0);
    check("t3_valid_drop", 32'(vld0), 32'd0);
    q0.push_back('{8'h01, 1'b0});
    send_frame(8'h01, 1'b1);
    tick();

    // Timeout after start + 3 data bits
    base = abort_cnt0;
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    for (int k = 1; k <= 15; k++) tick();
    check("t4_abort_early", 32'(abort0), 32'd0);
    check("t4_busy_early", 32'(busy0), 32'd1);
    tick();
    check("t4_abort_16", 32'(abort0), 32'd1);
    check("t4_busy_after", 32'(busy0), 32'd0);
    tick();
    check("t4_abort_pulse", 32'(abort0), 32'd0);
    check("t4_no_valid", 32'(vld0), 32'd0);
    check("t4_abort_count", 32'(abort_cnt0 - base), 32'd1);
    q0.push_back('{8'hFF, 1'b0});
    send_frame(8'hFF, 1'b0);
    tick();

    // Reset mid-frame after 4 data bits
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rst_n = 1'b0;
    tick();
    check("t5_rst_valid", 32'(vld0), 32'd0);
    check("t5_rst_busy", 32'(busy0), 32'd0);
    check("t5_rst_data", 32'(data0), 32'd0);
    check("t5_rst_err", 32'(err0), 32'd0);
    check("t5_rst_abort", 32'(abort0), 32'd0);
    check("t5_rst_overrun", 32'(ovr0), 32'd0);
    rst_n = 1'b1;
    q0.push_back('{8'h81, 1'b0});
    send_frame(8'h81, 1'b0);
    tick();

    // Odd-parity instance
    sel_odd = 1'b1;
    q1.push_back('{8'h00, 1'b0});
    send_frame(8'h00, 1'b1);
    check("t6_odd_valid", 32'(vld1), 32'd1);
    tick();
    q1.push_back('{8'h00, 1'b1});
    send_frame(8'h00, 1'b0);
    tick();
    sel_odd = 1'b0;
    tick();

    check("end_abort_even", 32'(abort_cnt0), 32'd1);
    check("end_overrun_even", 32'(ovr_cnt0), 32'd1);
    check("end_abort_odd", 32'(abort_cnt1), 32'd0);
    check("end_overrun_odd", 32'(ovr_cnt1), 32'd0);
    check("end_q_even", 32'(q0.size()), 32'd0);
    check("end_q_odd", 32'(q1.size()), 32'd0);
    check("end_busy_odd", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
